sub_result_bcd: RTL

Downstream stage of the 4-bit full subtractor. Takes the (WIDTH+1)-bit two's-complement difference S, handshakes it in, and converts it to sign plus packed BCD magnitude with a sequential double-dabble. The converted result is held on a valid/ready output for the display/readout stage.

---
 rtl/sub_pkg.sv | 15 +
 rtl/sub_bcd_add3.sv | 18 +
 rtl/sub_result_bcd.sv | 105 ++++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and defaults for the subtractor result readout path.
// Holds the conversion FSM encoding and the default operand/BCD sizing.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 4;
  localparam int DEF_DIGITS = 2;
  localparam int BCD_W      = 4;

endpackage

// File: rtl/sub_bcd_add3.sv
// Double-dabble digit corrector: adds 3 to a BCD digit holding 5 or more.
// Purely combinational, no handshake.
module sub_bcd_add3
  import sub_pkg::*;
(
  input  logic [BCD_W-1:0] digit,
  output logic [BCD_W-1:0] fixed
);

  localparam logic [BCD_W-1:0] FIVE  = BCD_W'(5);
  localparam logic [BCD_W-1:0] THREE = BCD_W'(3);

  always_comb begin
    fixed = digit;
    if (digit >= FIVE) fixed = digit + THREE;
  end

endmodule

// File: rtl/sub_result_bcd.sv
// Converts the subtractor's two's-complement difference to sign + packed BCD magnitude.
// WIDTH+1 shift cycles after accept; result held on out_valid until out_ready, in_ready low meanwhile.
module sub_result_bcd
  import sub_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH:0]            in_s,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_sign,
  output logic [BCD_W*DIGITS-1:0]   out_bcd
);

  localparam int BCD_BITS = BCD_W * DIGITS;
  localparam int CNT_W    = $clog2(WIDTH + 2);
  localparam int TOT_W    = BCD_BITS + WIDTH + 1;

  localparam logic [WIDTH:0]     MAG_ONE  = {{WIDTH{1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(WIDTH + 1);

  state_t               state;
  state_t               state_nxt;
  logic                 sign;
  logic [WIDTH:0]       mag;
  logic [WIDTH:0]       mag_in;
  logic [BCD_BITS-1:0]  bcd_work;
  logic [BCD_BITS-1:0]  bcd_fix;
  logic [CNT_W-1:0]     cnt;
  logic [TOT_W-1:0]     shifted;
  logic                 accept;
  logic                 last_iter;
  logic                 handshake;

  assign in_ready  = (state == IDLE);
  assign accept    = in_ready && in_valid;
  assign last_iter = (state == SHIFT) && (cnt == CNT_ONE);
  assign handshake = out_valid && out_ready;

  // Magnitude is one bit wider than the operands so the most negative value (-2^WIDTH) fits.
  assign mag_in  = in_s[WIDTH] ? (~in_s + MAG_ONE) : in_s;
  assign shifted = {bcd_fix, mag} << 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    sub_bcd_add3 u_add3 (
      .digit (bcd_work[g*BCD_W +: BCD_W]),
      .fixed (bcd_fix[g*BCD_W +: BCD_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (cnt == CNT_ONE) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign     <= 1'b0;
      mag      <= '0;
      bcd_work <= '0;
      cnt      <= '0;
    end else if (accept) begin
      sign     <= in_s[WIDTH];
      mag      <= mag_in;
      bcd_work <= '0;
      cnt      <= CNT_LOAD;
    end else if (state == SHIFT) begin
      bcd_work <= shifted[TOT_W-1:WIDTH+1];
      mag      <= shifted[WIDTH:0];
      cnt      <= cnt - CNT_ONE;
    end
  end

  // Result registers only move on the final shift, so they keep the last answer after readout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_bcd   <= '0;
    end else if (last_iter) begin
      out_valid <= 1'b1;
      out_sign  <= sign;
      out_bcd   <= shifted[TOT_W-1:WIDTH+1];
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

endmodule
